// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus between decode/execute and fetch_pc_unit. `slave` is the unit side, `master` the driver side.
// resolveValid has no ready: a resolve is consumed in the cycle it is presented, and is ignored if nothing is in flight.
interface fetch_pc_unit_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic        Stall;
  logic        isBranchF;
  logic        prediction;
  logic [7:0]  predTarget;
  logic        resolveValid;
  logic        resolveTaken;
  logic [7:0]  resolveTarget;

  logic [7:0]  pc;
  logic [7:0]  pcPlus1;
  logic        flush;
  logic [7:0]  CorrectedPC;
  logic        queueFull;
  logic [15:0] mispredCount;
  logic [CW-1:0] occupancy;

  modport slave (
    input  Stall, isBranchF, prediction, predTarget,
    input  resolveValid, resolveTaken, resolveTarget,
    output pc, pcPlus1, flush, CorrectedPC, queueFull, mispredCount, occupancy
  );

  modport master (
    output Stall, isBranchF, prediction, predTarget,
    output resolveValid, resolveTaken, resolveTarget,
    input  pc, pcPlus1, flush, CorrectedPC, queueFull, mispredCount, occupancy
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator with an in-flight branch prediction FIFO and mispredict redirect.
// Optional misprediction counter enabled by macro FETCH_MISPRED_COUNT_EN.
module fetch_pc_unit #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  fetch_pc_unit_if.slave    bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic       q_dir  [DEPTH];
  logic [7:0] q_fall [DEPTH];
  logic [7:0] q_tgt  [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    pc_q;

  logic       empty;
  logic       full;
  logic       pop;
  logic       push;
  logic       mispredict;
  logic       flush;
  logic       head_dir;
  logic [7:0] head_fall;
  logic [7:0] head_tgt;
  logic [7:0] pc_plus1;
  logic [7:0] corrected_pc;
  logic [7:0] next_pc;

  always_comb begin
    head_dir     = q_dir[rd_ptr];
    head_fall    = q_fall[rd_ptr];
    head_tgt     = q_tgt[rd_ptr];
    pc_plus1     = pc_q + 8'd1;
    empty        = (count == '0);
    full         = (count == CW'(DEPTH));
    pop          = bus.resolveValid && !empty;

    mispredict   = 1'b0;
    if (pop) begin
      mispredict = (bus.resolveTaken != head_dir) ||
                   (bus.resolveTaken && (bus.resolveTarget != head_tgt));
    end
    // Reset masks the redirect so outputs are quiet while reset is held.
    flush        = mispredict && !reset;

    corrected_pc = 8'h00;
    if (flush) begin
      corrected_pc = bus.resolveTaken ? bus.resolveTarget : head_fall;
    end

    push = bus.isBranchF && !bus.Stall && !full && !flush;

    if (flush) begin
      next_pc = corrected_pc;
    end else if (bus.Stall) begin
      next_pc = pc_q;
    end else if (bus.isBranchF && full) begin
      next_pc = pc_q;
    end else if (bus.isBranchF && bus.prediction) begin
      next_pc = bus.predTarget;
    end else begin
      next_pc = pc_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      pc_q <= next_pc;
      if (flush) begin
        // Everything younger than the mispredicted branch is wrong-path.
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry payload needs no reset; occupancy decides validity.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      q_dir[wr_ptr]  <= bus.prediction;
      q_fall[wr_ptr] <= pc_plus1;
      q_tgt[wr_ptr]  <= bus.predTarget;
    end
  end

`ifdef FETCH_MISPRED_COUNT_EN
  logic [15:0] mispred_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mispred_q <= 16'h0000;
    end else if (flush && (mispred_q != 16'hFFFF)) begin
      mispred_q <= mispred_q + 16'd1;
    end
  end

  assign bus.mispredCount = mispred_q;
`else
  assign bus.mispredCount = 16'h0000;
`endif

  assign bus.pc          = pc_q;
  assign bus.pcPlus1     = pc_plus1;
  assign bus.flush       = flush;
  assign bus.CorrectedPC = corrected_pc;
  assign bus.queueFull   = full;
  assign bus.occupancy   = count;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_pc_unit;
  localparam int DEPTH = 4;

  typedef struct {
    bit         dir;
    logic [7:0] fall;
    logic [7:0] tgt;
  } ent_t;

  logic clk;
  logic reset;

  fetch_pc_unit_if #(.DEPTH(DEPTH)) bus ();

  fetch_pc_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors;
  int          checks;
  ent_t        mq[$];
  logic [7:0]  exp_pc;
  logic [15:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset(input int n, input bit with_misp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset             = 1'b1;
      bus.Stall         = 1'($urandom_range(0, 1));
      bus.isBranchF     = 1'($urandom_range(0, 1));
      bus.prediction    = 1'($urandom_range(0, 1));
      bus.predTarget    = 8'($urandom);
      bus.resolveValid  = with_misp ? 1'b1 : 1'($urandom_range(0, 1));
      bus.resolveTaken  = with_misp ? 1'b1 : 1'($urandom_range(0, 1));
      bus.resolveTarget = 8'($urandom);
      #1;
      check("rst_flush", 32'(bus.flush), 32'd0);
      check("rst_corr", 32'(bus.CorrectedPC), 32'd0);
      if (i > 0) begin
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_full", 32'(bus.queueFull), 32'd0);
        check("rst_occ", 32'(bus.occupancy), 32'd0);
        check("rst_cnt", 32'(bus.mispredCount), 32'd0);
      end
    end
    mq.delete();
    exp_pc  = 8'h00;
    exp_cnt = 16'h0000;
  endtask

  // One clock of stimulus: outputs are compared at negedge+1, then the model advances.
  task automatic drive(input bit st, input bit br, input bit pr, input logic [7:0] pt,
                       input bit rv, input bit rt, input logic [7:0] rtg);
    bit         e_flush;
    logic [7:0] e_corr;
    bit         e_full;
    ent_t       h;
    @(negedge clk);
    reset             = 1'b0;
    bus.Stall         = st;
    bus.isBranchF     = br;
    bus.prediction    = pr;
    bus.predTarget    = pt;
    bus.resolveValid  = rv;
    bus.resolveTaken  = rt;
    bus.resolveTarget = rtg;
    #1;
    e_flush = 1'b0;
    e_corr  = 8'h00;
    e_full  = (mq.size() == DEPTH);
    if (rv && mq.size() > 0) begin
      h = mq[0];
      if (rt != h.dir) e_flush = 1'b1;
      else if (rt && rtg != h.tgt) e_flush = 1'b1;
      if (e_flush) e_corr = rt ? rtg : h.fall;
    end
    check("pc", 32'(bus.pc), 32'(exp_pc));
    check("pc_plus1", 32'(bus.pcPlus1), 32'(8'(exp_pc + 8'd1)));
    check("flush", 32'(bus.flush), 32'(e_flush));
    check("corr_pc", 32'(bus.CorrectedPC), 32'(e_corr));
    check("queue_full", 32'(bus.queueFull), 32'(e_full));
    check("occupancy", 32'(bus.occupancy), 32'(mq.size()));
    check("mispred_cnt", 32'(bus.mispredCount), 32'(exp_cnt));

    if (e_flush) begin
      mq.delete();
`ifdef FETCH_MISPRED_COUNT_EN
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
      exp_pc = e_corr;
    end else begin
      if (rv && mq.size() > 0) void'(mq.pop_front());
      if (br && !st && !e_full) mq.push_back('{dir: pr, fall: 8'(exp_pc + 8'd1), tgt: pt});
      if (st || (br && e_full)) exp_pc = exp_pc;
      else if (br && pr)        exp_pc = pt;
      else                      exp_pc = 8'(exp_pc + 8'd1);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  // Uses one mispredict to land the PC anywhere; queue must be empty on entry.
  task automatic redirect_to(input logic [7:0] t);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, t);
  endtask

  initial begin
    logic [7:0] held_pc;
    logic [7:0] rtg;
    errors            = 0;
    checks            = 0;
    reset             = 1'b1;
    bus.Stall         = 1'b0;
    bus.isBranchF     = 1'b0;
    bus.prediction    = 1'b0;
    bus.predTarget    = 8'h00;
    bus.resolveValid  = 1'b0;
    bus.resolveTaken  = 1'b0;
    bus.resolveTarget = 8'h00;

    do_reset(2, 1'b0);

    // Idle count-up from reset.
    for (int k = 0; k < 4; k++) begin
      idle();
      check("idle_pc", 32'(bus.pc), 32'(k));
      check("idle_flush", 32'(bus.flush), 32'd0);
    end

    // Correctly predicted taken branch at pc 5.
    idle();
    drive(1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 8'h00);
    check("br5_pc", 32'(bus.pc), 32'h05);
    idle();
    check("br5_tgt", 32'(bus.pc), 32'h20);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h20);
    check("br5_noflush", 32'(bus.flush), 32'd0);
    idle();
    check("br5_empty", 32'(bus.occupancy), 32'd0);

    // Not-taken prediction at pc 10 resolves taken with younger entries queued.
    redirect_to(8'h0A);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("br10_pc", 32'(bus.pc), 32'h0A);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 8'h40);
    check("br10_flush", 32'(bus.flush), 32'd1);
    check("br10_corr", 32'(bus.CorrectedPC), 32'h40);
    idle();
    check("br10_redirect", 32'(bus.pc), 32'h40);
    check("br10_empty", 32'(bus.occupancy), 32'd0);

    // Direction right, target wrong.
    redirect_to(8'h07);
    drive(1'b0, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0, 8'h00);
    check("br7_pc", 32'(bus.pc), 32'h07);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h31);
    check("br7_flush", 32'(bus.flush), 32'd1);
    check("br7_corr", 32'(bus.CorrectedPC), 32'h31);

    // Fill the queue, stall on the extra branch, then free one slot.
    idle();
    for (int k = 0; k < DEPTH; k++) drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("full_flag", 32'(bus.queueFull), 32'd1);
    held_pc = bus.pc;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("full_hold", 32'(bus.pc), 32'(held_pc));
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("full_cleared", 32'(bus.queueFull), 32'd0);
    check("full_hold2", 32'(bus.pc), 32'(held_pc));
    idle();
    check("full_advance", 32'(bus.pc), 32'(8'(held_pc + 8'd1)));
    check("full_refill", 32'(bus.occupancy), 32'(DEPTH));
    for (int k = 0; k < DEPTH; k++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // PC wrap.
    redirect_to(8'hFF);
    idle();
    check("wrap_ff", 32'(bus.pc), 32'hFF);
    idle();
    check("wrap_00", 32'(bus.pc), 32'h00);

    // Counter after exactly three mispredicts from reset.
    do_reset(2, 1'b0);
    redirect_to(8'h11);
    redirect_to(8'h22);
    redirect_to(8'h33);
    idle();
`ifdef FETCH_MISPRED_COUNT_EN
    check("cnt3", 32'(bus.mispredCount), 32'd3);
`else
    check("cnt3", 32'(bus.mispredCount), 32'd0);
`endif

    // Reset wins over a concurrent mispredict.
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    do_reset(2, 1'b1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) rtg = mq[0].tgt;
      else rtg = 8'($urandom);
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
            8'($urandom), $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), rtg);
      if (n == 1500) do_reset(2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL provide `DEPTH`, default 4: in-flight branch prediction queue entries; power of two, 2..8.
REQ-002 SHALL provide ports:
- `clk`, in, 1: single clock, all state on rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `Stall`, in, 1: hazard stall from decode; holds PC.
- `isBranchF`, in, 1: instruction at current `pc` is a conditional branch.
- `prediction`, in, 1: direction predicted for current `pc` (1 = taken).
- `predTarget`, in, 8: taken target for current `pc`.
- `resolveValid`, in, 1: oldest in-flight branch resolved this cycle.
- `resolveTaken`, in, 1: actual direction of resolved branch.
- `resolveTarget`, in, 8: actual taken target of resolved branch.
- `pc`, out, 8: current fetch PC (registered).
- `pcPlus1`, out, 8: `pc`+1 modulo 256 (combinational).
- `flush`, out, 1: mispredict detected this cycle (combinational).
- `CorrectedPC`, out, 8: redirect PC; valid while `flush`=1, else 0.
- `queueFull`, out, 1: prediction queue holds `DEPTH` entries.
- `mispredCount`, out, 16: misprediction counter (see Configuration).

Function
REQ-003 Each queue entry SHALL hold: predicted direction, fall-through PC (`pc`+1), predicted target.
REQ-004 Push SHALL occur when `isBranchF`=1, `Stall`=0, `queueFull`=0, and no flush this cycle.
REQ-005 Pop SHALL occur when `resolveValid`=1 and the queue is non-empty.
- `resolveValid` with an empty queue SHALL be ignored: no pop, no flush.
REQ-006 A popped entry SHALL flag a mispredict when:
- actual direction differs from predicted direction, or
- both are taken and `resolveTarget` differs from the stored predicted target.
REQ-007 On mispredict, in the same cycle:
- `flush`=1.
- `CorrectedPC` = `resolveTarget` if `resolveTaken`, else the stored fall-through PC.
REQ-008 Next-PC priority SHALL be:
1. Mispredict → `CorrectedPC`.
2. `Stall`=1 → hold `pc`.
3. `isBranchF`=1 and `queueFull`=1 → hold `pc` (internal fetch stall).
4. `isBranchF`=1 and `prediction`=1 → `predTarget`.
5. Otherwise → `pcPlus1`.
REQ-009 On mispredict, the queue SHALL be emptied at the next edge (all younger entries are wrong-path); any simultaneous push SHALL be dropped.
REQ-010 Simultaneous push and non-mispredicting pop SHALL leave occupancy unchanged; write and read pointers SHALL wrap modulo `DEPTH`.
REQ-011 `pc` arithmetic SHALL be 8-bit unsigned with wrap: 255+1 = 0.
REQ-012 Redirect latency SHALL be one cycle: `pc` equals `CorrectedPC` on the edge following `flush`.
REQ-013 `queueFull` SHALL be registered-occupancy derived: asserted iff occupancy = `DEPTH`.

Reset
REQ-014 While `reset`=1 at an edge, the block SHALL set:
- `pc`=0.
- Queue occupancy 0, both pointers 0.
- `mispredCount`=0.
REQ-015 During reset, outputs SHALL settle to `flush`=0, `CorrectedPC`=0, `queueFull`=0.
REQ-016 Reset SHALL override all other inputs, including a concurrent mispredict.

Configuration
REQ-017 With macro `FETCH_MISPRED_COUNT_EN` defined:
- `mispredCount` SHALL increment by 1 on each cycle with `flush`=1.
- It SHALL saturate at 16'hFFFF.
REQ-018 Without `FETCH_MISPRED_COUNT_EN`, `mispredCount` SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- Reset, then 3 idle cycles → `pc` = 0, 1, 2, 3; `flush`=0 throughout.
- `pc`=5, `isBranchF`=1, `prediction`=1, `predTarget`=8'h20; later resolve taken, target 8'h20 → `pc` goes 5→8'h20, no flush, queue empties.
- Branch at `pc`=10 predicted not-taken; resolve taken, target 8'h40, 2 younger entries queued → `flush`=1, `CorrectedPC`=8'h40, next `pc`=8'h40, occupancy 0.
- Branch predicted taken with target 8'h30 from `pc`=7; resolve taken with target 8'h31 → flush, `CorrectedPC`=8'h31.
- Fill queue to `DEPTH`=4, present another branch → `queueFull`=1 and `pc` holds; one pop → next-cycle push and PC advance.
- `pc`=8'hFF, no branch → `pc`=0.
- With macro defined, 3 mispredicts → `mispredCount`=3; without the macro → stays 0.
